// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types for the snooping bus controller: bus operations, controller
// states, MSI block-state encodings and a lowest-set-bit helper.
package coherence_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    NOOP     = 2'b00,
    BUS_RD   = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_UPGR = 2'b11
  } bus_op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SNOOP = 3'd1,
    INV   = 3'd2,
    XFER  = 3'd3,
    MEM   = 3'd4,
    DONE  = 3'd5
  } bus_state_t;

  typedef enum logic [1:0] {
    MSI_I = 2'b00,
    MSI_S = 2'b01,
    MSI_M = 2'b10
  } msi_state_t;

  // Index of the lowest set bit (0 when none set); up to 8 cores.
  function automatic logic [2:0] lowest_set_idx(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping modulo NUM_CPU.
module coherence_bus_ctrl_rr_arbiter #(
  parameter int NUM_CPU = 4
) (
  input  logic [NUM_CPU-1:0]         req,
  input  logic [$clog2(NUM_CPU)-1:0] ptr,
  output logic                       valid,
  output logic [NUM_CPU-1:0]         gnt,
  output logic [$clog2(NUM_CPU)-1:0] idx
);
  localparam int IDX_W = $clog2(NUM_CPU);

  logic [IDX_W-1:0] cand_s;

  // Scan candidates starting at the pointer; the first requester wins.
  always_comb begin
    valid  = 1'b0;
    gnt    = '0;
    idx    = '0;
    cand_s = '0;
    for (int i = 0; i < NUM_CPU; i++) begin
      cand_s = IDX_W'((int'(ptr) + i) % NUM_CPU);
      if (!valid && req[cand_s]) begin
        valid       = 1'b1;
        gnt[cand_s] = 1'b1;
        idx         = cand_s;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: round-robin snooping bus controller for NUM_CPU private
// MSI D-caches sharing one dmem port. All outputs are registered.
// Optional build macro BUS_WDOG_EN: memory-wait watchdog that aborts a
// transaction with a one-cycle bus_err pulse after WDOG_CYCLES cycles.
module coherence_bus_ctrl #(
  parameter int NUM_CPU     = 4,
  parameter int ADDR_W      = 13,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CPU-1:0]          rd_miss,
  input  logic [NUM_CPU-1:0]          wr_miss,
  input  logic [NUM_CPU-1:0]          upgr,
  input  logic [NUM_CPU*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CPU-1:0]          snoop_hit,
  input  logic [NUM_CPU-1:0]          snoop_dirty,
  input  logic                        mem_rdy,
  output logic [NUM_CPU-1:0]          grant,
  output logic [ADDR_W-1:0]           bus_addr,
  output logic [1:0]                  bus_op,
  output logic [NUM_CPU-1:0]          snoop_req,
  output logic [NUM_CPU-1:0]          inv,
  output logic                        fill_from_cpu,
  output logic [$clog2(NUM_CPU)-1:0]  fill_src,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [NUM_CPU-1:0]          done,
  output logic                        bus_err
);
  import coherence_bus_ctrl_pkg::*;

  localparam int IDX_W = $clog2(NUM_CPU);

  bus_state_t         state_r, state_s;
  logic [IDX_W-1:0]   owner_idx_r, ptr_r, arb_idx_s, dirty_idx_s;
  logic [NUM_CPU-1:0] owner_oh_r, owner_oh_nxt_s, arb_gnt_s, req_any_s, dirty_s;
  bus_op_t            op_r, arb_op_s, op_nxt_s;
  logic [ADDR_W-1:0]  addr_r, arb_addr_s, addr_nxt_s;
  logic [ADDR_W-1:0]  addr_arr_s [NUM_CPU];
  logic               arb_valid_s, dirty_any_s, wdog_expire_s, active_s;

  logic [NUM_CPU-1:0] grant_s, snoop_req_s, inv_s, done_s;
  logic [ADDR_W-1:0]  bus_addr_s;
  bus_op_t            bus_op_s;
  logic               ffc_s, mem_req_s, mem_we_s, bus_err_s;
  logic [IDX_W-1:0]   fill_src_s;

  // Clean hits never supply data, so snoop_hit only matters to the caches.
  logic unused_hit_s;
  assign unused_hit_s = ^snoop_hit;

  // Collapse per-core request kinds and split the packed address bus.
  always_comb begin
    req_any_s = rd_miss | wr_miss | upgr;
    for (int i = 0; i < NUM_CPU; i++) begin
      addr_arr_s[i] = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  coherence_bus_ctrl_rr_arbiter #(.NUM_CPU(NUM_CPU)) u_arb (
    .req   (req_any_s),
    .ptr   (ptr_r),
    .valid (arb_valid_s),
    .gnt   (arb_gnt_s),
    .idx   (arb_idx_s)
  );

  // Winner's operation (upgrade beats write miss beats read miss) and address.
  always_comb begin
    if (upgr[arb_idx_s]) begin
      arb_op_s = BUS_UPGR;
    end else if (wr_miss[arb_idx_s]) begin
      arb_op_s = BUS_RDX;
    end else if (rd_miss[arb_idx_s]) begin
      arb_op_s = BUS_RD;
    end else begin
      arb_op_s = NOOP;
    end
    arb_addr_s = addr_arr_s[arb_idx_s];
  end

  // Dirty owner among the snooped cores; lowest index wins on a protocol error.
  always_comb begin
    dirty_s     = snoop_dirty & ~owner_oh_r;
    dirty_any_s = |dirty_s;
    dirty_idx_s = IDX_W'(lowest_set_idx(8'(dirty_s)));
  end

`ifdef BUS_WDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_cnt_r;

  assign wdog_expire_s = ((state_r == MEM) || (state_r == XFER)) && !mem_rdy &&
                         (wdog_cnt_r == WD_W'(WDOG_CYCLES - 1));

  // Count consecutive cycles spent waiting on dmem; clear on any exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_r <= '0;
    end else if (((state_r == MEM) || (state_r == XFER)) && (state_s == state_r)) begin
      wdog_cnt_r <= wdog_cnt_r + WD_W'(1);
    end else begin
      wdog_cnt_r <= '0;
    end
  end
`else
  logic unused_wdog_s;
  assign unused_wdog_s = (WDOG_CYCLES != 0);
  assign wdog_expire_s = 1'b0;
`endif

  // Next-state logic of the transaction FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (arb_valid_s) state_s = SNOOP;
        else             state_s = IDLE;
      end
      SNOOP: begin
        if (op_r == BUS_UPGR) state_s = INV;
        else if (dirty_any_s) state_s = XFER;
        else                  state_s = MEM;
      end
      INV: state_s = DONE;
      XFER, MEM: begin
        if (mem_rdy)            state_s = DONE;
        else if (wdog_expire_s) state_s = IDLE;
        else                    state_s = state_r;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    active_s       = (state_s != IDLE);
    owner_oh_nxt_s = (state_r == IDLE) ? arb_gnt_s  : owner_oh_r;
    op_nxt_s       = (state_r == IDLE) ? arb_op_s   : op_r;
    addr_nxt_s     = (state_r == IDLE) ? arb_addr_s : addr_r;
    grant_s        = active_s ? owner_oh_nxt_s : '0;
    bus_addr_s     = active_s ? addr_nxt_s : '0;
    bus_op_s       = active_s ? op_nxt_s : NOOP;
    snoop_req_s    = (state_s == SNOOP) ? ~owner_oh_nxt_s : '0;
    if (state_s == INV) begin
      inv_s = ~owner_oh_r;
    end else if ((state_r == SNOOP) && (op_r == BUS_RDX) &&
                 ((state_s == MEM) || (state_s == XFER))) begin
      inv_s = ~owner_oh_r;
    end else begin
      inv_s = '0;
    end
    mem_req_s = (state_s == MEM) || (state_s == XFER);
    mem_we_s  = (state_s == XFER);
    done_s    = (state_s == DONE) ? owner_oh_r : '0;
    if (state_r == SNOOP) begin
      ffc_s      = (state_s == XFER);
      fill_src_s = (state_s == XFER) ? dirty_idx_s : '0;
    end else if (state_s == IDLE) begin
      ffc_s      = 1'b0;
      fill_src_s = '0;
    end else begin
      ffc_s      = fill_from_cpu;
      fill_src_s = fill_src;
    end
    bus_err_s = wdog_expire_s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Latch the winning core, operation and address at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_idx_r <= '0;
      owner_oh_r  <= '0;
      op_r        <= NOOP;
      addr_r      <= '0;
    end else if ((state_r == IDLE) && arb_valid_s) begin
      owner_idx_r <= arb_idx_s;
      owner_oh_r  <= arb_gnt_s;
      op_r        <= arb_op_s;
      addr_r      <= arb_addr_s;
    end else begin
      owner_idx_r <= owner_idx_r;
      owner_oh_r  <= owner_oh_r;
      op_r        <= op_r;
      addr_r      <= addr_r;
    end
  end

  // Round-robin pointer moves past the owner on completion or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else if ((state_r == DONE) || wdog_expire_s) begin
      ptr_r <= (owner_idx_r == IDX_W'(NUM_CPU - 1)) ? '0 : owner_idx_r + IDX_W'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant         <= '0;
      bus_addr      <= '0;
      bus_op        <= NOOP;
      snoop_req     <= '0;
      inv           <= '0;
      fill_from_cpu <= 1'b0;
      fill_src      <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      done          <= '0;
      bus_err       <= 1'b0;
    end else begin
      grant         <= grant_s;
      bus_addr      <= bus_addr_s;
      bus_op        <= bus_op_s;
      snoop_req     <= snoop_req_s;
      inv           <= inv_s;
      fill_from_cpu <= ffc_s;
      fill_src      <= fill_src_s;
      mem_req       <= mem_req_s;
      mem_we        <= mem_we_s;
      done          <= done_s;
      bus_err       <= bus_err_s;
    end
  end

endmodule

// File: doc/coherence_bus_ctrl.md
Name: coherence_bus_ctrl

Overview:
- Parametrised snooping bus controller for an N-core MSI system; successor to the fixed two-core bus.
- Arbitrates read-miss, write-miss and upgrade (invalidate) requests from NUM_CPU private D-caches with round-robin fairness.
- Broadcasts snoops, selects the fill source (owning cache or dmem), drives invalidates and dirty write-back to dmem, and signals completion per core.
- Sits between the per-core cache controllers and the shared dmem port.

Parameters:
- NUM_CPU, 4, number of cores; 2..8.
- ADDR_W, 13, full block address width.
- WDOG_CYCLES, 64, memory wait limit; used only with BUS_WDOG_EN.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rd_miss  in  NUM_CPU  per-core read-miss request
- wr_miss  in  NUM_CPU  per-core write-miss request
- upgr  in  NUM_CPU  per-core upgrade (S->M) request
- req_addr  in  NUM_CPU*ADDR_W  per-core address; core i at bits [i*ADDR_W +: ADDR_W]
- snoop_hit  in  NUM_CPU  snooped core holds the block valid (S or M)
- snoop_dirty  in  NUM_CPU  snooped core holds the block in M
- mem_rdy  in  1  dmem access complete
- grant  out  NUM_CPU  one-hot owner of current transaction
- bus_addr  out  ADDR_W  address of current transaction
- bus_op  out  2  bus_op_t: NOOP, BUS_RD, BUS_RDX, BUS_UPGR
- snoop_req  out  NUM_CPU  snoop strobe to every non-owner core
- inv  out  NUM_CPU  invalidate strobe to non-owner cores
- fill_from_cpu  out  1  fill data comes from a cache, not dmem
- fill_src  out  $clog2(NUM_CPU)  index of the supplying cache
- mem_req  out  1  dmem access request
- mem_we  out  1  dmem write (dirty write-back)
- done  out  NUM_CPU  one-cycle completion pulse to the requester
- bus_err  out  1  one-cycle watchdog abort pulse

Behaviour:
- Reset: all outputs 0, bus_op=NOOP, state IDLE, round-robin pointer 0. A reset asserted mid-transaction aborts it with no done pulse.
- Request handshake: a core holds its request until its done pulse. Changes to its request or address after grant are ignored until DONE.
- Per-core request priority: upgr > wr_miss > rd_miss.
- Arbitration (IDLE): pick the first requesting core at or after the pointer, wrapping modulo NUM_CPU. Latch index, op and address. After DONE (or abort), the pointer becomes winner+1, wrapping to 0.
- SNOOP (1 cycle): grant, bus_addr and bus_op valid; snoop_req = ~grant; snoop_hit and snoop_dirty are sampled at the end of this cycle.
- BUS_UPGR path: SNOOP -> INV (1 cycle, inv=~grant) -> DONE. No dmem access.
- BUS_RD or BUS_RDX with any dirty hit: SNOOP -> XFER.
  - fill_from_cpu=1; fill_src = lowest-index dirty core (multiple dirty hits are a protocol error; lowest index wins).
  - mem_req=1, mem_we=1 (write-back); hold until mem_rdy.
  - For BUS_RDX, inv=~grant is asserted in XFER's first cycle.
  - XFER -> DONE.
- BUS_RD or BUS_RDX with no dirty hit: SNOOP -> MEM.
  - mem_req=1, mem_we=0; hold until mem_rdy.
  - fill_from_cpu=0, fill_src=0.
  - For BUS_RDX, inv=~grant in MEM's first cycle.
  - MEM -> DONE.
- DONE (1 cycle): done[owner]=1; grant stays asserted; the pointer advances.
- DONE -> IDLE.
- Clean shared hits do not supply data; dmem fills.
- mem_rdy sampled high in the cycle mem_req first asserts completes the access in that cycle. Minimum transaction: 4 cycles (IDLE grant, SNOOP, MEM/XFER, DONE).
- Cache state transitions are owned by the caches, driven by bus_op plus inv.
- Outside active states, grant, snoop_req, inv, mem_req and done are 0.

Optional Feature:
- BUS_WDOG_EN defined: a counter runs in MEM/XFER.
  - If mem_rdy is absent for WDOG_CYCLES cycles: pulse bus_err for 1 cycle, drop mem_req, go to IDLE without done, and advance the pointer.
- Not defined: no counter; bus_err is tied 0; waits on mem_rdy indefinitely.

Decomposition:
- Shared package (common): bus_op_t, bus_state_t (IDLE, SNOOP, INV, XFER, MEM, DONE), and MSI block-state encodings (I=2'b00, S=2'b01, M=2'b10).
- Sub-module rr_arbiter: NUM_CPU-wide request vector plus pointer in, one-hot grant and index out.

Test Plan (NUM_CPU=4):
- Clean read miss: rd_miss[2], addr 13'h0A4, no hits, mem_rdy 2 cycles later → grant=4'b0100, bus_op=BUS_RD, snoop_req=4'b1011, mem_we=0, done[2] pulses; total 5 cycles.
- Dirty read miss: rd_miss[0], snoop_dirty[3] → fill_from_cpu=1, fill_src=3, mem_we=1, inv=0, done[0] pulses.
- Upgrade: upgr[1] → INV cycle with inv=4'b1101, no mem_req, done[1] four cycles after request.
- Round robin: rd_miss on cores 0, 1 and 3 all held continuously, pointer 0 → service order 0, 1, 3, then 0.
- Reset mid-operation: rst during MEM with rd_miss[1] → next cycle all outputs 0, pointer 0, no done pulse.
- BUS_WDOG_EN with WDOG_CYCLES=8, mem_rdy held low → bus_err pulses exactly once, returns to IDLE, done stays 0.
